tcdm_burst_splitter: RTL

Splits one multi-word burst request from a DMA frontend or accelerator port into single-word TCDM requests and reassembles the per-word responses into one burst response. It generalises the fixed four-word DMA access to a parametrised burst length. It adds a bounded number of outstanding words and out-of-order response reordering by word ID. It sits between a wide requester and a single tile's narrow TCDM port.

---
 rtl/tcdm_burst_splitter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/tcdm_burst_splitter.sv
// Burst-to-word splitter for a single TCDM port.
// Issues words with a bounded in-flight count and reorders responses by id.
module tcdm_burst_splitter #(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxBurstLen    = 8,
    parameter int NumOutstanding = 4,
    parameter int BeWidth        = DataWidth / 8,
    parameter int LenWidth       = $clog2(MaxBurstLen + 1),
    parameter int IdWidth        = $clog2(MaxBurstLen)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             burst_req_valid_i,
    output logic                             burst_req_ready_o,
    input  logic [AddrWidth-1:0]             burst_req_addr_i,
    input  logic [LenWidth-1:0]              burst_req_len_i,
    input  logic                             burst_req_wen_i,
    input  logic [BeWidth-1:0]               burst_req_be_i,
    input  logic [MaxBurstLen*DataWidth-1:0] burst_req_wdata_i,
    output logic                             burst_rsp_valid_o,
    input  logic                             burst_rsp_ready_i,
    output logic [MaxBurstLen*DataWidth-1:0] burst_rsp_data_o,
    output logic                             burst_rsp_err_o,
    output logic                             tcdm_req_valid_o,
    input  logic                             tcdm_req_ready_i,
    output logic [AddrWidth-1:0]             tcdm_req_addr_o,
    output logic                             tcdm_req_wen_o,
    output logic [BeWidth-1:0]               tcdm_req_be_o,
    output logic [DataWidth-1:0]             tcdm_req_wdata_o,
    output logic [IdWidth-1:0]               tcdm_req_id_o,
    input  logic                             tcdm_rsp_valid_i,
    input  logic [IdWidth-1:0]               tcdm_rsp_id_i,
    input  logic [DataWidth-1:0]             tcdm_rsp_data_i
);

    localparam int OutWidth = $clog2(NumOutstanding + 1);
    localparam int BeShift  = $clog2(BeWidth);
    localparam logic [LenWidth-1:0] MaxLen = LenWidth'(MaxBurstLen);
    localparam logic [OutWidth-1:0] OutMax = OutWidth'(NumOutstanding);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0]             addr_q;
    logic                             wen_q;
    logic [BeWidth-1:0]               be_q;
    logic [MaxBurstLen*DataWidth-1:0] wdata_q;
    logic [MaxBurstLen*DataWidth-1:0] data_q;
    logic [LenWidth-1:0]              len_q;
    logic [LenWidth-1:0]              issue_cnt_q;
    logic [OutWidth-1:0]              outst_cnt_q;
    logic [MaxBurstLen-1:0]           mask_q;
    logic [MaxBurstLen-1:0]           mask_d;
    logic [MaxBurstLen-1:0]           full_mask;
    logic                             err_q;

    logic                capture;
    logic                req_hs;
    logic                rsp_ok;
    logic                last_issue;
    logic                all_done;
    logic [LenWidth-1:0] eff_len;
    logic [IdWidth-1:0]  issue_id;

    assign eff_len  = (burst_req_len_i > MaxLen) ? MaxLen : burst_req_len_i;
    assign issue_id = issue_cnt_q[IdWidth-1:0];
    assign capture  = (state_q == ISSUE) || (state_q == WAIT);

    assign tcdm_req_valid_o = (state_q == ISSUE) && (outst_cnt_q < OutMax);
    assign tcdm_req_addr_o  = addr_q + (AddrWidth'(issue_cnt_q) << BeShift);
    assign tcdm_req_wen_o   = wen_q;
    assign tcdm_req_be_o    = be_q;
    assign tcdm_req_wdata_o = wdata_q[issue_id*DataWidth +: DataWidth];
    assign tcdm_req_id_o    = issue_id;

    assign burst_req_ready_o = (state_q == IDLE);
    assign burst_rsp_valid_o = (state_q == RESP);
    assign burst_rsp_data_o  = data_q;
    assign burst_rsp_err_o   = err_q;

    assign req_hs     = tcdm_req_valid_o && tcdm_req_ready_i;
    assign last_issue = req_hs && (issue_cnt_q == len_q - LenWidth'(1));
    assign rsp_ok     = capture && tcdm_rsp_valid_i
                     && (LenWidth'(tcdm_rsp_id_i) < len_q)
                     && !mask_q[tcdm_rsp_id_i];
    assign mask_d     = rsp_ok ? (mask_q | (MaxBurstLen'(1) << tcdm_rsp_id_i))
                               : mask_q;
    assign all_done   = (mask_d == full_mask);

    // Slots below the latched length that must be filled before responding.
    always_comb begin
        full_mask = '0;
        for (int k = 0; k < MaxBurstLen; k++) begin
            full_mask[k] = (k < int'(len_q));
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; completion looks at the mask including this cycle's response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (burst_req_valid_i) begin
                    state_d = (eff_len == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_d = all_done ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (all_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (burst_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst latch, issue/outstanding counters and response reassembly.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            wen_q       <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            outst_cnt_q <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
        end else if (state_q == IDLE) begin
            if (burst_req_valid_i) begin
                addr_q      <= burst_req_addr_i;
                wen_q       <= burst_req_wen_i;
                be_q        <= burst_req_be_i;
                wdata_q     <= burst_req_wdata_i;
                len_q       <= eff_len;
                data_q      <= '0;
                issue_cnt_q <= '0;
                outst_cnt_q <= '0;
                mask_q      <= '0;
                err_q       <= 1'b0;
            end
        end else begin
            if (req_hs) begin
                issue_cnt_q <= issue_cnt_q + LenWidth'(1);
            end
            if (req_hs && !rsp_ok) begin
                outst_cnt_q <= outst_cnt_q + OutWidth'(1);
            end else if (!req_hs && rsp_ok) begin
                outst_cnt_q <= outst_cnt_q - OutWidth'(1);
            end
            if (rsp_ok) begin
                mask_q <= mask_d;
                if (!wen_q) begin
                    data_q[tcdm_rsp_id_i*DataWidth +: DataWidth] <= tcdm_rsp_data_i;
                end
            end
            if (capture && tcdm_rsp_valid_i && !rsp_ok) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
